// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the sequential ALU: opcode encodings,
//               FSM state type, output flag bundle and the iterative-unit
//               mode encodings.
// Ports       : none (package)
// Config      : ALU_SEQ_MUL_EN enables opcode OP_MUL in the design.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Opcodes (zero-extended to OP_WIDTH where compared)
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    // Top-level control FSM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alu_state_e;

    // Flags that travel with every result
    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    // Operation selector for the iterative datapath
    localparam logic [1:0] ITER_SLL = 2'd0;
    localparam logic [1:0] ITER_SRL = 2'd1;
    localparam logic [1:0] ITER_SRA = 2'd2;
    localparam logic [1:0] ITER_MUL = 2'd3;

endpackage
`default_nettype wire

// File: rtl/alu_seq_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_iter
// Description : Iterative datapath of the sequential ALU. Shifts advance one
//               bit per step; the optional multiplier performs one shift-add
//               step per cycle for WIDTH steps.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start_i             - load operands and step count
//               mode_i              - ITER_SLL/SRL/SRA/MUL
//               x_i, y_i, shamt_i   - operands / shift amount
//               step_i              - advance one step (ignored at count 0)
//               done_o              - result_o is final (last step or held)
//               result_o, ovf_o     - final value, multiply overflow
// Config      : ALU_SEQ_MUL_EN adds the shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [SHIFT-1:0] shamt_i,
    input  logic             step_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    // Counter must hold WIDTH for the multiply as well as any shift amount
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_shift_res;
    logic             w_adv;

    assign w_adv = step_i && (cnt_q != '0);

    always_comb begin
        w_step_val = val_q;
        case (mode_q)
            ITER_SLL: w_step_val = {val_q[WIDTH-2:0], 1'b0};
            ITER_SRL: w_step_val = {1'b0, val_q[WIDTH-1:1]};
            ITER_SRA: w_step_val = {val_q[WIDTH-1], val_q[WIDTH-1:1]};
            default:  w_step_val = val_q;
        endcase
    end

    // With one step left the next value is already final, so it is handed
    // out combinationally and the consumer can capture it on this edge.
    assign done_o      = (cnt_q <= CW'(1));
    assign w_shift_res = (cnt_q == '0) ? val_q : w_step_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= ITER_SLL;
            cnt_q  <= '0;
            val_q  <= '0;
        end else if (start_i) begin
            mode_q <= mode_i;
            val_q  <= x_i;
            cnt_q  <= (mode_i == ITER_MUL) ? CW'(WIDTH) : CW'(shamt_i);
        end else if (w_adv) begin
            val_q  <= w_step_val;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;

    assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_prod     = (cnt_q == '0) ? acc_q : w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, x_i};
            mplier_q <= y_i;
        end else if (w_adv) begin
            acc_q    <= w_acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign result_o = (mode_q == ITER_MUL) ? w_prod[WIDTH-1:0] : w_shift_res;
    assign ovf_o    = (mode_q == ITER_MUL) && (|w_prod[2*WIDTH-1:WIDTH]);
`else
    // y is only consumed by the multiplier
    logic w_unused_y;
    assign w_unused_y = ^y_i;

    assign result_o = w_shift_res;
    assign ovf_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_sequential.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequential
// Description : Handshaked ALU. Logic, add/sub and SLT complete in one cycle;
//               shifts (and the optional multiply) run on alu_seq_iter.
//               Results and flags sit in a one-entry output register with a
//               valid/ready handshake.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               in_valid/in_ready             - input handshake
//               operation, x, y, shamt, carry_in - opcode and operands
//               out_valid/out_ready           - output handshake
//               result, zero, negative, carry, overflow, illegal - outputs
// Config      : ALU_SEQ_MUL_EN enables opcode 9 (iterative unsigned multiply);
//               otherwise opcode 9 reports illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequential
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SHIFT    = $clog2(WIDTH),
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] operation,
    input  logic [WIDTH-1:0]    x,
    input  logic [WIDTH-1:0]    y,
    input  logic [SHIFT-1:0]    shamt,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                negative,
    output logic                carry,
    output logic                overflow,
    output logic                illegal
);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_free, w_accept, w_pop;

    assign w_free   = !out_valid_q || out_ready;
    assign in_ready = (state_q == IDLE) && w_free;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid_q && out_ready;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic w_op_and, w_op_or, w_op_xor, w_op_add, w_op_sub;
    logic w_op_sll, w_op_srl, w_op_slt, w_op_sra, w_op_mul;
    logic w_op_shift;

    assign w_op_and = (operation == OP_WIDTH'(OP_AND));
    assign w_op_or  = (operation == OP_WIDTH'(OP_OR));
    assign w_op_xor = (operation == OP_WIDTH'(OP_XOR));
    assign w_op_add = (operation == OP_WIDTH'(OP_ADD));
    assign w_op_sub = (operation == OP_WIDTH'(OP_SUB));
    assign w_op_sll = (operation == OP_WIDTH'(OP_SLL));
    assign w_op_srl = (operation == OP_WIDTH'(OP_SRL));
    assign w_op_slt = (operation == OP_WIDTH'(OP_SLT));
    assign w_op_sra = (operation == OP_WIDTH'(OP_SRA));
`ifdef ALU_SEQ_MUL_EN
    assign w_op_mul = (operation == OP_WIDTH'(OP_MUL));
`else
    assign w_op_mul = 1'b0;
`endif
    assign w_op_shift = w_op_sll || w_op_srl || w_op_sra;

    // Zero-distance shifts bypass the iterative unit
    logic w_go_busy;
    assign w_go_busy = w_accept && ((w_op_shift && (shamt != '0)) || w_op_mul);

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_add, w_sub;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_carry, w_sc_ovf, w_sc_ill;

    assign w_add = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry_in};
    // Bit WIDTH of the extended difference is the unsigned borrow
    assign w_sub = {1'b0, x} - {1'b0, y};

    always_comb begin
        w_sc_res   = '0;
        w_sc_carry = 1'b0;
        w_sc_ovf   = 1'b0;
        w_sc_ill   = 1'b0;
        if (w_op_and) begin
            w_sc_res = x & y;
        end else if (w_op_or) begin
            w_sc_res = x | y;
        end else if (w_op_xor) begin
            w_sc_res = x ^ y;
        end else if (w_op_add) begin
            w_sc_res   = w_add[WIDTH-1:0];
            w_sc_carry = w_add[WIDTH];
            w_sc_ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (w_add[WIDTH-1] != x[WIDTH-1]);
        end else if (w_op_sub) begin
            w_sc_res   = w_sub[WIDTH-1:0];
            w_sc_carry = w_sub[WIDTH];
            w_sc_ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (w_sub[WIDTH-1] != x[WIDTH-1]);
        end else if (w_op_slt) begin
            w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
        end else if (w_op_shift) begin
            w_sc_res = x;
        end else begin
            w_sc_ill = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Iterative unit
    // ------------------------------------------------------------------
    logic [1:0]       w_it_mode;
    logic             w_it_done, w_it_ovf;
    logic [WIDTH-1:0] w_it_res;

    always_comb begin
        w_it_mode = ITER_SLL;
        if (w_op_srl)      w_it_mode = ITER_SRL;
        else if (w_op_sra) w_it_mode = ITER_SRA;
        else if (w_op_mul) w_it_mode = ITER_MUL;
    end

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (w_go_busy),
        .mode_i   (w_it_mode),
        .x_i      (x),
        .y_i      (y),
        .shamt_i  (shamt),
        .step_i   (state_q == BUSY),
        .done_o   (w_it_done),
        .result_o (w_it_res),
        .ovf_o    (w_it_ovf)
    );

    // ------------------------------------------------------------------
    // FSM and output register
    // ------------------------------------------------------------------
    logic w_wr_sc, w_wr_it;

    assign w_wr_sc = w_accept && !w_go_busy;
    assign w_wr_it = (state_q == BUSY) && w_it_done && w_free;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_go_busy) state_d = BUSY;
            BUSY:    if (w_wr_it)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A write in the same cycle as a pop overrides the clear, keeping out_valid high
    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (w_pop) out_valid_d = 1'b0;
        if (w_wr_sc) begin
            result_d          = w_sc_res;
            flags_d.zero      = (w_sc_res == '0);
            flags_d.negative  = w_sc_res[WIDTH-1];
            flags_d.carry     = w_sc_carry;
            flags_d.overflow  = w_sc_ovf;
            flags_d.illegal   = w_sc_ill;
            out_valid_d       = 1'b1;
        end else if (w_wr_it) begin
            result_d          = w_it_res;
            flags_d.zero      = (w_it_res == '0);
            flags_d.negative  = w_it_res[WIDTH-1];
            flags_d.carry     = 1'b0;
            flags_d.overflow  = w_it_ovf;
            flags_d.illegal   = 1'b0;
            out_valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign illegal   = flags_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequential.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequential
// Description : Self-checking bench for alu_sequential (WIDTH=8): directed
//               steps from the test plan followed by random operations,
//               compared against an arithmetic reference model.
// Config      : ALU_SEQ_MUL_EN selects multiply expectations for opcode 9.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequential;

    localparam int W  = 8;
    localparam int SH = 3;
    localparam int OW = 4;
    localparam int M  = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] operation = '0;
    logic [W-1:0]  x = '0, y = '0;
    logic [SH-1:0] shamt = '0;
    logic          carry_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero, negative, carry, overflow, illegal;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequential #(.WIDTH(W), .SHIFT(SH), .OP_WIDTH(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .x         (x),
        .y         (y),
        .shamt     (shamt),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    function automatic logic [4:0] dut_flags();
        return {zero, negative, carry, overflow, illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; flags packed {z,n,c,v,ill}
    function automatic void ref_model(input int op, input int xa, input int ya,
                                      input int sh, input int cin,
                                      output int r, output int fl);
        int sx, sy, full, c, v, ill;
        sx = (xa >= M/2) ? xa - M : xa;
        sy = (ya >= M/2) ? ya - M : ya;
        c = 0; v = 0; ill = 0; r = 0;
        case (op)
            0: r = xa & ya;
            1: r = xa | ya;
            2: r = xa ^ ya;
            3: begin
                full = xa + ya + cin;
                r = full % M;
                c = (full >= M) ? 1 : 0;
                v = (sx + sy + cin > M/2 - 1 || sx + sy + cin < -M/2) ? 1 : 0;
            end
            4: begin
                r = (xa - ya + M) % M;
                c = (xa < ya) ? 1 : 0;
                v = (sx - sy > M/2 - 1 || sx - sy < -M/2) ? 1 : 0;
            end
            5: r = (xa << sh) % M;
            6: r = xa >> sh;
            7: r = (sx < sy) ? 1 : 0;
            8: r = (sx >>> sh) & (M - 1);
`ifdef ALU_SEQ_MUL_EN
            9: begin
                full = xa * ya;
                r = full % M;
                v = (full >= M) ? 1 : 0;
            end
`endif
            default: begin r = 0; ill = 1; end
        endcase
        fl = ((r == 0) ? 16 : 0) | (((r >> (W-1)) & 1) << 3) | (c << 2) | (v << 1) | ill;
    endfunction

    function automatic int exp_lat(input int op, input int sh);
        if ((op == 5 || op == 6 || op == 8) && sh != 0) return 1 + sh;
`ifdef ALU_SEQ_MUL_EN
        if (op == 9) return 1 + W;
`endif
        return 1;
    endfunction

    // One full transaction with a ready consumer: accept, latency, result, flags
    task automatic do_op(input string tag, input int op, input int xa, input int ya,
                         input int sh, input int cin);
        int r, fl, lat, n, acc;
        ref_model(op, xa, ya, sh, cin, r, fl);
        lat = exp_lat(op, sh);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operation = op[OW-1:0];
        x = xa[W-1:0]; y = ya[W-1:0]; shamt = sh[SH-1:0]; carry_in = cin[0];
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk({tag, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: captured operands must not change
        x = ~x; y = ~y; shamt = ~shamt; operation = ~operation;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 200) begin
            if (lat > 1) chk({tag, "_busy_inready"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, cyc - acc, lat);
        chk({tag, "_result"}, {24'd0, result}, r);
        chk({tag, "_flags"}, {27'd0, dut_flags()}, fl);
    endtask

    initial begin
        int seen;
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst_flags", {27'd0, dut_flags()}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        rst_n = 1'b1;

        // ---------------- test-plan directed ops ----------------
        do_op("add_7f_01", 3, 'h7F, 'h01, 0, 0);   // 0x80, n=1 v=1
        do_op("sub_05_07", 4, 'h05, 'h07, 0, 0);   // 0xFE, c=1 n=1
        do_op("slt_ff_01", 7, 'hFF, 'h01, 0, 0);   // 1
        do_op("sra_90_3", 8, 'h90, 0, 3, 0);       // 0xF2, latency 4
        do_op("sll_81_1", 5, 'h81, 0, 1, 0);
        do_op("srl_80_7", 6, 'h80, 0, 7, 0);
        do_op("sll_sh0", 5, 'hA5, 0, 0, 0);
        do_op("add_cin", 3, 'hFF, 'h00, 0, 1);     // carry out, zero
        do_op("op9", 9, 'h10, 'h11, 0, 0);
        do_op("illegal_12", 12, 'h33, 'h44, 0, 0);

        // ---------------- stalled consumer ----------------
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; operation = 4'd3; x = 8'h12; y = 8'h34; carry_in = 1'b1; shamt = '0;
        @(posedge clk);
        #1;
        operation = 4'd2; x = 8'hF0; y = 8'h0F; carry_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 1);
            chk("stall_in_ready", {31'd0, in_ready}, 0);
            chk("stall_result", {24'd0, result}, 'h47);
            chk("stall_flags", {27'd0, dut_flags()}, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_second_valid", {31'd0, out_valid}, 1);
        chk("stall_second_result", {24'd0, result}, 'hFF);
        chk("stall_second_flags", {27'd0, dut_flags()}, 5'b01000);

        // ---------------- back-to-back throughput ----------------
        @(negedge clk);
        in_valid = 1'b1; operation = 4'd0; x = 8'hF0; y = 8'h3C;
        @(posedge clk);
        #1;
        operation = 4'd1; x = 8'h01; y = 8'h02;
        @(negedge clk);
        chk("b2b_first_valid", {31'd0, out_valid}, 1);
        chk("b2b_first_result", {24'd0, result}, 'h30);
        chk("b2b_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_valid", {31'd0, out_valid}, 1);
        chk("b2b_second_result", {24'd0, result}, 'h03);
        @(negedge clk);
        chk("b2b_drained", {31'd0, out_valid}, 0);

        // ---------------- reset during a long shift ----------------
        do_op("pre_reset_add", 3, 'h7F, 'h01, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; operation = 4'd5; x = 8'h01; shamt = 3'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midshift_in_ready_busy", {31'd0, in_ready}, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_result", {24'd0, result}, 0);
        chk("midrst_flags", {27'd0, dut_flags()}, 0);
        chk("midrst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("aborted_op_silent", seen, 0);
        do_op("post_reset_add", 3, 'h12, 'h34, 0, 0);

        // ---------------- random operations ----------------
        for (int i = 0; i < 40; i++) begin
            do_op("rand", $urandom_range(0, 15), $urandom_range(0, M-1),
                  $urandom_range(0, M-1), $urandom_range(0, W-1), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
